// File: rtl/mem_arb2_if.sv
// Tile-memory port bundle: the master drives address, operation and write data;
// the slave returns read data and status.
interface mem_arb2_if;
  logic [31:0]  addr;
  logic [4:0]   opm;
  logic [127:0] data_out;
  logic [127:0] data_in;
  logic [1:0]   ok;

  modport master (output addr, opm, data_out, input data_in, ok);
  modport slave  (input addr, opm, data_out, output data_in, ok);
endinterface

// File: rtl/mem_arb2.sv
// Two-master tile-memory arbiter (A = I-cache, B = D-cache) in front of a single
// downstream port; round-robin or fixed-priority on ties, one transaction at a time.
module mem_arb2 #(
  parameter int ARB_FIXED = 0
) (
  input logic        clock,
  input logic        reset,
  mem_arb2_if.slave  a_port,
  mem_arb2_if.slave  b_port,
  mem_arb2_if.master mem
);

  localparam logic [4:0] UMEM_OPM_READY = 5'h00;
  localparam logic [1:0] UMEM_OK_READY  = 2'd0;
  localparam logic [1:0] UMEM_OK_OK     = 2'd1;
  localparam logic [1:0] UMEM_OK_HOLD   = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    GNT_A,
    GNT_B,
    DONE_A,
    DONE_B
  } state_t;

  state_t         state, state_n;
  logic           last_gnt, last_gnt_n;   // 0 = A was granted last
  logic [31:0]    addr_q, addr_n;
  logic [4:0]     opm_q, opm_n;
  logic [127:0]   wdata_q, wdata_n;

  logic a_req, b_req;
  logic a_gnt, b_gnt;

  assign a_req = (a_port.opm != UMEM_OPM_READY);
  assign b_req = (b_port.opm != UMEM_OPM_READY);
  assign a_gnt = (state == GNT_A) || (state == DONE_A);
  assign b_gnt = (state == GNT_B) || (state == DONE_B);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      addr_q   <= '0;
      opm_q    <= UMEM_OPM_READY;
      wdata_q  <= '0;
    end else begin
      state    <= state_n;
      last_gnt <= last_gnt_n;
      addr_q   <= addr_n;
      opm_q    <= opm_n;
      wdata_q  <= wdata_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    last_gnt_n = last_gnt;
    addr_n     = addr_q;
    opm_n      = UMEM_OPM_READY;
    wdata_n    = wdata_q;

    case (state)
      IDLE: begin
        if (a_req && b_req) begin
          state_n = ((ARB_FIXED != 0) || last_gnt) ? GNT_A : GNT_B;
        end else if (a_req) begin
          state_n = GNT_A;
        end else if (b_req) begin
          state_n = GNT_B;
        end
      end

      // The granted master is forwarded every cycle, including a dropped
      // request; only an OK from downstream ends the grant phase.
      GNT_A: begin
        addr_n  = a_port.addr;
        opm_n   = a_port.opm;
        wdata_n = a_port.data_out;
        if (mem.ok == UMEM_OK_OK) state_n = DONE_A;
      end

      GNT_B: begin
        addr_n  = b_port.addr;
        opm_n   = b_port.opm;
        wdata_n = b_port.data_out;
        if (mem.ok == UMEM_OK_OK) state_n = DONE_B;
      end

      DONE_A: begin
        if (!a_req && (mem.ok == UMEM_OK_READY)) begin
          state_n    = IDLE;
          last_gnt_n = 1'b0;
        end
      end

      DONE_B: begin
        if (!b_req && (mem.ok == UMEM_OK_READY)) begin
          state_n    = IDLE;
          last_gnt_n = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign mem.addr     = addr_q;
  assign mem.opm      = opm_q;
  assign mem.data_out = wdata_q;

  // Losers see HOLD while requesting so they keep their request asserted.
  assign a_port.ok      = a_gnt ? mem.ok : (a_req ? UMEM_OK_HOLD : UMEM_OK_READY);
  assign b_port.ok      = b_gnt ? mem.ok : (b_req ? UMEM_OK_HOLD : UMEM_OK_READY);
  assign a_port.data_in = mem.data_in;
  assign b_port.data_in = mem.data_in;

endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2: a round-robin instance and a fixed-priority
// instance driven cycle by cycle with hand-computed expectations.
module tb_mem_arb2;

  localparam logic [4:0] OPM_READY = 5'h00;
  localparam logic [4:0] OPM_RD    = 5'h0A;
  localparam logic [4:0] OPM_WR    = 5'h0B;
  localparam logic [1:0] OK_READY  = 2'd0;
  localparam logic [1:0] OK_OK     = 2'd1;
  localparam logic [1:0] OK_HOLD   = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_arb2_if a0 ();
  mem_arb2_if b0 ();
  mem_arb2_if m0 ();
  mem_arb2_if a1 ();
  mem_arb2_if b1 ();
  mem_arb2_if m1 ();

  mem_arb2 #(.ARB_FIXED(0)) dut_rr (
    .clock  (clock),
    .reset  (reset),
    .a_port (a0),
    .b_port (b0),
    .mem    (m0)
  );

  mem_arb2 #(.ARB_FIXED(1)) dut_fx (
    .clock  (clock),
    .reset  (reset),
    .a_port (a1),
    .b_port (b1),
    .mem    (m1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns 2 time units after the next rising edge, clear of the edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    a0.opm = OPM_READY; a0.addr = '0; a0.data_out = '0;
    b0.opm = OPM_RD;    b0.addr = '0; b0.data_out = '0;
    m0.ok  = OK_OK;     m0.data_in = '0;
    a1.opm = OPM_READY; a1.addr = '0; a1.data_out = '0;
    b1.opm = OPM_READY; b1.addr = '0; b1.data_out = '0;
    m1.ok  = OK_READY;  m1.data_in = '0;

    // Reset values, with B requesting while reset is held.
    #12;
    check("rst_mem_opm",   m0.opm,      OPM_READY);
    check("rst_mem_addr",  m0.addr,     32'h0);
    check("rst_mem_wdata", m0.data_out, 128'h0);
    check("rst_a_ok",      a0.ok,       OK_READY);
    check("rst_b_ok_req",  b0.ok,       OK_HOLD);
    b0.opm = OPM_READY;
    @(negedge clock);
    reset = 1'b1;

    // Stray OK while idle must not start anything.
    tick(); tick();
    check("idle_ok_a",   a0.ok,  OK_READY);
    check("idle_ok_b",   b0.ok,  OK_READY);
    check("idle_ok_opm", m0.opm, OPM_READY);
    m0.ok = OK_READY;

    // First tie after reset: A wins; A does a read with three HOLD cycles.
    a0.opm = OPM_RD; a0.addr = 32'h0000_1230; a0.data_out = {4{32'h1111_2222}};
    b0.opm = OPM_WR; b0.addr = 32'h0000_B000; b0.data_out = {4{32'hBBBB_0000}};
    #1;
    check("tie1_idle_a_hold", a0.ok, OK_HOLD);
    check("tie1_idle_b_hold", b0.ok, OK_HOLD);
    tick();                                   // GNT_A
    check("tie1_a_granted",   a0.ok,  OK_READY);
    check("tie1_b_hold",      b0.ok,  OK_HOLD);
    check("tie1_opm_latency", m0.opm, OPM_READY);
    m0.ok = OK_HOLD;
    #1;
    check("tie1_a_fwd_hold", a0.ok, OK_HOLD);
    tick();                                   // GNT_A, A registered
    check("rd_a_opm",   m0.opm,      OPM_RD);
    check("rd_a_addr",  m0.addr,     32'h0000_1230);
    check("rd_a_wdata", m0.data_out, {4{32'h1111_2222}});
    tick(); tick();
    check("rd_a_b_still_hold", b0.ok, OK_HOLD);
    m0.ok = OK_OK; m0.data_in = {16{8'hA5}};
    #1;
    check("rd_a_ok",    a0.ok,      OK_OK);
    check("rd_a_rdata", a0.data_in, {16{8'hA5}});
    tick();                                   // DONE_A
    a0.opm = OPM_READY; m0.ok = OK_READY;
    #1;
    check("done_a_ok_fwd", a0.ok, OK_READY);
    check("done_a_b_hold", b0.ok, OK_HOLD);
    tick();                                   // IDLE, last = A
    check("exit_a_opm",       m0.opm,  OPM_READY);
    check("exit_a_addr_hold", m0.addr, 32'h0000_1230);
    check("exit_a_b_hold",    b0.ok,   OK_HOLD);
    tick();                                   // GNT_B, back-to-back
    check("b2b_b_granted", b0.ok, OK_READY);
    tick();
    check("wr_b_opm",   m0.opm,      OPM_WR);
    check("wr_b_addr",  m0.addr,     32'h0000_B000);
    check("wr_b_wdata", m0.data_out, {4{32'hBBBB_0000}});
    m0.ok = OK_OK; m0.data_in = {16{8'h5A}};
    #1;
    check("wr_b_ok",    b0.ok,      OK_OK);
    check("wr_b_rdata", b0.data_in, {16{8'h5A}});
    tick();                                   // DONE_B
    b0.opm = OPM_READY; m0.ok = OK_READY;
    tick();                                   // IDLE, last = B

    // Third tie goes back to A.
    a0.opm = OPM_RD; a0.addr = 32'h0000_3000;
    b0.opm = OPM_RD; b0.addr = 32'h0000_4000;
    #1;
    tick();                                   // GNT_A
    check("tie3_a_granted", a0.ok, OK_READY);
    check("tie3_b_hold",    b0.ok, OK_HOLD);
    tick();
    check("tie3_a_addr", m0.addr, 32'h0000_3000);
    m0.ok = OK_OK;
    tick();                                   // DONE_A
    a0.opm = OPM_READY; m0.ok = OK_READY;
    tick();                                   // IDLE
    tick();                                   // GNT_B
    check("tie3_b_after", b0.ok, OK_READY);
    tick();
    check("tie3_b_addr", m0.addr, 32'h0000_4000);

    // B drops its request mid-grant: READY is forwarded, grant is kept.
    b0.opm = OPM_READY; m0.ok = OK_HOLD;
    #1;
    check("drop_b_ok_fwd", b0.ok, OK_HOLD);
    tick();
    check("drop_b_opm_fwd", m0.opm, OPM_READY);
    check("drop_b_still",   b0.ok,  OK_HOLD);
    m0.ok = OK_OK;
    tick();                                   // DONE_B
    m0.ok = OK_READY;
    tick();                                   // IDLE
    check("drop_b_exit", b0.ok, OK_READY);

    // A releases slowly; B arrives during DONE_A and must wait.
    a0.opm = OPM_RD; a0.addr = 32'h0000_5000;
    tick();                                   // GNT_A
    tick();
    check("slow_a_addr", m0.addr, 32'h0000_5000);
    m0.ok = OK_OK;
    tick();                                   // DONE_A
    m0.ok = OK_READY;
    b0.opm = OPM_WR; b0.addr = 32'h0000_6000; b0.data_out = {4{32'h6666_0000}};
    #1;
    check("late_b_hold", b0.ok, OK_HOLD);
    tick();
    check("slow_a_opm_ready", m0.opm,  OPM_READY);
    check("slow_a_granted",   a0.ok,   OK_READY);
    check("late_b_addr_kept", m0.addr, 32'h0000_5000);
    check("late_b_hold2",     b0.ok,   OK_HOLD);
    tick();
    check("slow_a_granted2", a0.ok, OK_READY);
    a0.opm = OPM_READY; m0.ok = OK_HOLD;
    #1;
    check("slow_a_memhold", a0.ok, OK_HOLD);
    tick();
    check("slow_a_need_ready", a0.ok, OK_HOLD);
    m0.ok = OK_READY;
    tick();                                   // IDLE
    check("late_b_idle_hold", b0.ok, OK_HOLD);
    tick();                                   // GNT_B
    check("late_b_granted", b0.ok, OK_READY);
    tick();
    check("late_b_opm",  m0.opm,  OPM_WR);
    check("late_b_addr", m0.addr, 32'h0000_6000);
    m0.ok = OK_HOLD;

    // Asynchronous reset in the middle of B's write.
    #3;
    reset = 1'b0;
    #1;
    check("arst_opm",   m0.opm,  OPM_READY);
    check("arst_addr",  m0.addr, 32'h0);
    check("arst_b_idle", b0.ok,  OK_HOLD);
    b0.opm = OPM_READY; m0.ok = OK_READY;
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("arst_no_completion", m0.opm, OPM_READY);
    a0.opm = OPM_RD; a0.addr = 32'h0000_7000;
    #1;
    check("post_rst_a_hold", a0.ok, OK_HOLD);
    tick();                                   // GNT_A
    check("post_rst_a_granted", a0.ok, OK_READY);
    tick();
    check("post_rst_a_opm",  m0.opm,  OPM_RD);
    check("post_rst_a_addr", m0.addr, 32'h0000_7000);
    m0.ok = OK_OK;
    tick();
    a0.opm = OPM_READY; m0.ok = OK_READY;
    tick();

    // Fixed priority: A keeps winning ties; B only gets in when A is idle.
    a1.opm = OPM_RD; a1.addr = 32'h0000_0100;
    b1.opm = OPM_RD; b1.addr = 32'h0000_0200;
    #1;
    tick();                                   // GNT_A
    check("fx_a_first", a1.ok, OK_READY);
    check("fx_b_hold",  b1.ok, OK_HOLD);
    m1.ok = OK_OK;
    tick();                                   // DONE_A
    a1.opm = OPM_READY; m1.ok = OK_READY;
    tick();                                   // IDLE, last = A
    a1.opm = OPM_RD; a1.addr = 32'h0000_0104;
    #1;
    check("fx_tie_b_hold", b1.ok, OK_HOLD);
    tick();                                   // GNT_A again
    check("fx_a_again",  a1.ok, OK_READY);
    check("fx_b_hold2",  b1.ok, OK_HOLD);
    m1.ok = OK_OK;
    tick();
    a1.opm = OPM_READY; m1.ok = OK_READY;
    tick();                                   // IDLE, A idle
    #1;
    check("fx_idle_b_hold", b1.ok, OK_HOLD);
    tick();                                   // GNT_B
    check("fx_b_granted", b1.ok, OK_READY);
    tick();
    check("fx_b_addr", m1.addr, 32'h0000_0200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
